// File: rtl/boot_loader_ctrl_pkg.sv
// Shared types and constants for the boot loader: FSM states, frame magic,
// length field width and the running checksum step.
package boot_loader_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN0 = 3'd1,
    ST_LEN1 = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4,
    ST_RUN  = 3'd5,
    ST_ERR  = 3'd6
  } boot_state_e;

  localparam logic [7:0] BOOT_MAGIC = 8'hA5;
  localparam int         LEN_W      = 16;

  // Image checksum is a plain XOR over every payload byte.
  function automatic logic [7:0] csum_step(input logic [7:0] csum, input logic [7:0] b);
    return csum ^ b;
  endfunction

endpackage

// File: rtl/boot_word_assembler.sv
// Packs payload bytes little-endian into 32-bit words, keeps the XOR checksum
// and the word index, and issues one registered instruction-memory write per word.
module boot_word_assembler
  import boot_loader_ctrl_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_push,
  input  logic [7:0]        i_byte,
  output logic              o_last_lane,
  output logic [ADDR_W:0]   o_idx,
  output logic [7:0]        o_csum,
  output logic              o_we,
  output logic [31:0]       o_addr,
  output logic [31:0]       o_wdata
);

  localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]      r_lane;
  logic [23:0]     r_shift;
  logic [ADDR_W:0] r_idx;
  logic [7:0]      r_csum;
  logic            r_we;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;

  // Byte lane steering, checksum accumulation and the one-cycle write stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lane  <= 2'd0;
      r_shift <= 24'd0;
      r_idx   <= {(ADDR_W+1){1'b0}};
      r_csum  <= 8'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
    end else begin
      r_we <= 1'b0;
      if (i_clear) begin
        r_lane  <= 2'd0;
        r_shift <= 24'd0;
        r_idx   <= {(ADDR_W+1){1'b0}};
        r_csum  <= 8'd0;
      end else if (i_push) begin
        r_csum <= csum_step(r_csum, i_byte);
        r_lane <= r_lane + 2'd1;
        case (r_lane)
          2'd0: r_shift[7:0]   <= i_byte;
          2'd1: r_shift[15:8]  <= i_byte;
          2'd2: r_shift[23:16] <= i_byte;
          2'd3: begin
            // Address is taken from the index before it advances.
            r_we    <= 1'b1;
            r_wdata <= {i_byte, r_shift};
            r_addr  <= 32'({r_idx[ADDR_W-1:0], 2'b00});
            r_idx   <= r_idx + IDX_ONE;
          end
          default: r_shift <= r_shift;
        endcase
      end else begin
        r_lane <= r_lane;
      end
    end
  end

  assign o_last_lane = (r_lane == 2'd3);
  assign o_idx       = r_idx;
  assign o_csum      = r_csum;
  assign o_we        = r_we;
  assign o_addr      = r_addr;
  assign o_wdata     = r_wdata;

endmodule

// File: rtl/boot_loader_ctrl.sv
// Boot sequencer: holds the core halted, parses a framed image from the UART,
// writes it into instruction memory and releases the core once the checksum verifies.
module boot_loader_ctrl
  import boot_loader_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int MAX_WORDS   = 512,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_boot_bypass,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  output logic        o_imem_we,
  output logic [31:0] o_imem_addr,
  output logic [31:0] o_imem_wdata,
  output logic        o_core_run,
  output logic        o_boot_done,
  output logic        o_boot_err
);

  localparam int               TMO_W    = $clog2(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_WORDS);
  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [ADDR_W:0]  IDX_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  boot_state_e      r_state;
  boot_state_e      w_state_next;
  logic [7:0]       r_len_lo;
  logic [LEN_W-1:0] r_len;
  logic [TMO_W-1:0] r_tmo;
  logic             r_core_run;
  logic             r_boot_done;
  logic             r_boot_err;

  logic [LEN_W-1:0] w_len_n;
  logic             w_counting;
  logic             w_timeout;
  logic             w_asm_clear;
  logic             w_asm_push;
  logic             w_last_lane;
  logic [ADDR_W:0]  w_idx;
  logic [ADDR_W:0]  w_idx_inc;
  logic [7:0]       w_csum;

  boot_word_assembler #(
    .ADDR_W (ADDR_W)
  ) u_asm (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_asm_clear),
    .i_push      (w_asm_push),
    .i_byte      (i_rx_data),
    .o_last_lane (w_last_lane),
    .o_idx       (w_idx),
    .o_csum      (w_csum),
    .o_we        (o_imem_we),
    .o_addr      (o_imem_addr),
    .o_wdata     (o_imem_wdata)
  );

  assign w_len_n    = {i_rx_data, r_len_lo};
  assign w_idx_inc  = w_idx + IDX_ONE;
  assign w_counting = (r_state == ST_LEN0) || (r_state == ST_LEN1) ||
                      (r_state == ST_DATA) || (r_state == ST_CSUM);
  // A byte arriving on the expiry cycle wins because every state tests rx_valid first.
  assign w_timeout  = w_counting && (r_tmo == TMO_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode plus assembler control strobes.
  always_comb begin
    w_state_next = r_state;
    w_asm_clear  = 1'b0;
    w_asm_push   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_boot_bypass) begin
          w_state_next = ST_RUN;
        end else if (i_rx_valid && (i_rx_data == BOOT_MAGIC)) begin
          w_state_next = ST_LEN0;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_LEN0: begin
        if (i_rx_valid) begin
          w_state_next = ST_LEN1;
        end else if (w_timeout) begin
          w_state_next = ST_ERR;
        end else begin
          w_state_next = ST_LEN0;
        end
      end
      ST_LEN1: begin
        if (i_rx_valid) begin
          if ((w_len_n == LEN_ZERO) || (w_len_n > LEN_MAX)) begin
            w_state_next = ST_ERR;
          end else begin
            w_state_next = ST_DATA;
            w_asm_clear  = 1'b1;
          end
        end else if (w_timeout) begin
          w_state_next = ST_ERR;
        end else begin
          w_state_next = ST_LEN1;
        end
      end
      ST_DATA: begin
        if (i_rx_valid) begin
          w_asm_push = 1'b1;
          if (w_last_lane && (LEN_W'(w_idx_inc) == r_len)) begin
            w_state_next = ST_CSUM;
          end else begin
            w_state_next = ST_DATA;
          end
        end else if (w_timeout) begin
          w_state_next = ST_ERR;
        end else begin
          w_state_next = ST_DATA;
        end
      end
      ST_CSUM: begin
        if (i_rx_valid) begin
          if (i_rx_data == w_csum) begin
            w_state_next = ST_RUN;
          end else begin
            w_state_next = ST_ERR;
          end
        end else if (w_timeout) begin
          w_state_next = ST_ERR;
        end else begin
          w_state_next = ST_CSUM;
        end
      end
      ST_RUN: begin
        w_state_next = ST_RUN;
      end
      ST_ERR: begin
        if (i_rx_valid && (i_rx_data == BOOT_MAGIC)) begin
          w_state_next = ST_LEN0;
        end else begin
          w_state_next = ST_ERR;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Capture the two length bytes of the frame header.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_len_lo <= 8'd0;
      r_len    <= LEN_ZERO;
    end else if (i_rx_valid && (r_state == ST_LEN0)) begin
      r_len_lo <= i_rx_data;
    end else if (i_rx_valid && (r_state == ST_LEN1)) begin
      r_len    <= w_len_n;
    end else begin
      r_len_lo <= r_len_lo;
    end
  end

  // Inter-byte idle counter; only runs while a frame is in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tmo <= {TMO_W{1'b0}};
    end else if (i_rx_valid || !w_counting) begin
      r_tmo <= {TMO_W{1'b0}};
    end else if (w_timeout) begin
      r_tmo <= {TMO_W{1'b0}};
    end else begin
      r_tmo <= r_tmo + TMO_ONE;
    end
  end

  // Status outputs follow the state being entered so they are valid on its first cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_core_run  <= 1'b0;
      r_boot_done <= 1'b0;
      r_boot_err  <= 1'b0;
    end else begin
      r_core_run  <= (w_state_next == ST_RUN);
      r_boot_done <= (w_state_next == ST_RUN);
      r_boot_err  <= (w_state_next == ST_ERR);
    end
  end

  assign o_core_run  = r_core_run;
  assign o_boot_done = r_boot_done;
  assign o_boot_err  = r_boot_err;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Self-checking bench for boot_loader_ctrl: directed frames from the test plan
// plus randomized frames, checked against an image-level model of the loader.
module tb_boot_loader_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        boot_bypass;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_run;
  logic        boot_done;
  logic        boot_err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  logic [31:0] frame_words[$];

  always #5 clk = ~clk;

  boot_loader_ctrl #(
    .ADDR_W      (9),
    .MAX_WORDS   (512),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_boot_bypass(boot_bypass),
    .i_rx_valid   (rx_valid),
    .i_rx_data    (rx_data),
    .o_imem_we    (imem_we),
    .o_imem_addr  (imem_addr),
    .o_imem_wdata (imem_wdata),
    .o_core_run   (core_run),
    .o_boot_done  (boot_done),
    .o_boot_err   (boot_err)
  );

  // Record every memory write, sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      got_addr.push_back(imem_addr);
      got_data.push_back(imem_wdata);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    tick(gap);
    rx_valid = 1'b1;
    rx_data  = b;
    tick(1);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  function automatic int rgap(input int mx);
    return int'($urandom_range(mx, 0));
  endfunction

  function automatic logic [7:0] stray_byte();
    logic [7:0] b;
    b = 8'($urandom);
    if (b == 8'hA5) b = 8'h5A;
    return b;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    got_addr.delete();
    got_data.delete();
  endtask

  task automatic make_words(input int n);
    frame_words.delete();
    for (int i = 0; i < n; i++) frame_words.push_back($urandom);
  endtask

  // Sends magic, length, the payload of frame_words and the XOR checksum.
  // slow_idx selects one payload byte that arrives exactly on the timeout expiry cycle.
  task automatic send_frame(input logic [15:0] len_field, input bit bad, input int mx, input int slow_idx);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    send_byte(8'hA5, rgap(mx));
    send_byte(len_field[7:0], rgap(mx));
    send_byte(len_field[15:8], rgap(mx));
    for (int i = 0; i < frame_words.size(); i++) begin
      for (int l = 0; l < 4; l++) begin
        b  = frame_words[i][8*l +: 8];
        cs = cs ^ b;
        if ((4*i + l) == slow_idx) begin
          send_byte(b, 15);
          check_eq("t5.expiry_accept", {31'd0, boot_err}, 32'd0);
        end else begin
          send_byte(b, rgap(mx));
        end
      end
    end
    send_byte(bad ? (cs ^ 8'h01) : cs, rgap(mx));
  endtask

  // Model: word i of the image lands at byte address 4*i; the core runs only
  // when the checksum matched, otherwise the error flag is up and the core halted.
  task automatic check_outcome(input string tag, input bit ok, input int n_wr);
    tick(2);
    check_eq({tag, ".nwr"}, got_addr.size(), n_wr);
    for (int i = 0; i < n_wr && i < got_addr.size(); i++) begin
      check_eq({tag, ".addr"}, got_addr[i], 32'(4 * i));
      check_eq({tag, ".data"}, got_data[i], frame_words[i]);
    end
    check_eq({tag, ".run"},  {31'd0, core_run},  {31'd0, ok});
    check_eq({tag, ".done"}, {31'd0, boot_done}, {31'd0, ok});
    check_eq({tag, ".err"},  {31'd0, boot_err},  {31'd0, !ok});
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".we"},    {31'd0, imem_we},   32'd0);
    check_eq({tag, ".addr"},  imem_addr,          32'd0);
    check_eq({tag, ".wdata"}, imem_wdata,         32'd0);
    check_eq({tag, ".run"},   {31'd0, core_run},  32'd0);
    check_eq({tag, ".done"},  {31'd0, boot_done}, 32'd0);
    check_eq({tag, ".err"},   {31'd0, boot_err},  32'd0);
  endtask

  initial begin
    int  n;
    bit  bad;
    rst_n       = 1'b0;
    boot_bypass = 1'b0;
    rx_valid    = 1'b0;
    rx_data     = 8'h00;
    tick(3);
    check_reset_outputs("reset");

    // 1: bypass straight to RUN, no memory writes
    boot_bypass = 1'b1;
    rst_n       = 1'b1;
    tick(2);
    check_eq("t1.run",  {31'd0, core_run},  32'd1);
    check_eq("t1.done", {31'd0, boot_done}, 32'd1);
    check_eq("t1.err",  {31'd0, boot_err},  32'd0);
    send_byte(8'hA5, 0);
    tick(3);
    check_eq("t1.nwr", got_addr.size(), 32'd0);
    check_eq("t1.sticky", {31'd0, core_run}, 32'd1);
    boot_bypass = 1'b0;

    // 2: directed two-word image
    do_reset();
    frame_words = '{32'h0000_0013, 32'h0010_0093};
    send_frame(16'd2, 1'b0, 0, -1);
    check_outcome("t2", 1'b1, 2);

    // 3: bad checksum, then a corrected frame from the error state
    do_reset();
    send_frame(16'd2, 1'b1, 1, -1);
    check_outcome("t3bad", 1'b0, 2);
    got_addr.delete();
    got_data.delete();
    send_frame(16'd2, 1'b0, 1, -1);
    check_outcome("t3fix", 1'b1, 2);

    // 4: length errors (N=0, N=513)
    do_reset();
    send_byte(8'hA5, 0);
    send_byte(8'h00, 1);
    send_byte(8'h00, 0);
    check_eq("t4.len0.err", {31'd0, boot_err}, 32'd1);
    send_byte(8'hA5, 2);
    check_eq("t4.rearm.err", {31'd0, boot_err}, 32'd0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    check_eq("t4.len513.err", {31'd0, boot_err}, 32'd1);
    send_byte(stray_byte(), 0);
    tick(3);
    check_eq("t4.nwr", got_addr.size(), 32'd0);
    check_eq("t4.run", {31'd0, core_run}, 32'd0);

    // largest accepted image
    do_reset();
    make_words(512);
    send_frame(16'd512, 1'b0, 0, -1);
    check_outcome("max", 1'b1, 512);

    // 5: inter-byte timeout, then a byte landing exactly on the expiry cycle
    do_reset();
    make_words(2);
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(frame_words[0][7:0], 0);
    send_byte(frame_words[0][15:8], 0);
    tick(15);
    check_eq("t5.before", {31'd0, boot_err}, 32'd0);
    tick(1);
    check_eq("t5.expired", {31'd0, boot_err}, 32'd1);
    check_eq("t5.nwr0", got_addr.size(), 32'd0);
    send_frame(16'd2, 1'b0, 1, 2);
    check_outcome("t5", 1'b1, 2);

    // 6: reset in the middle of DATA after the second word is written
    do_reset();
    make_words(3);
    send_byte(8'hA5, 0);
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    for (int p = 0; p < 9; p++) send_byte(frame_words[p / 4][8*(p % 4) +: 8], rgap(1));
    tick(1);
    check_eq("t6.pre_nwr", got_addr.size(), 32'd2);
    rst_n = 1'b0;
    tick(1);
    check_reset_outputs("t6.rst");
    rst_n = 1'b1;
    got_addr.delete();
    got_data.delete();
    for (int s = 0; s < 3; s++) send_byte(stray_byte(), rgap(2));
    tick(2);
    check_eq("t6.stray_nwr", got_addr.size(), 32'd0);
    check_eq("t6.stray_err", {31'd0, boot_err}, 32'd0);
    make_words(2);
    send_frame(16'd2, 1'b0, 2, -1);
    check_outcome("t6", 1'b1, 2);

    // randomized images: length, contents, spacing, stray prefix, checksum corruption
    for (int k = 0; k < 10; k++) begin
      do_reset();
      n   = int'($urandom_range(8, 1));
      bad = ($urandom_range(2, 0) == 0);
      make_words(n);
      for (int s = 0; s < int'($urandom_range(3, 0)); s++) send_byte(stray_byte(), rgap(3));
      send_frame(16'(n), bad, 3, -1);
      check_outcome("rnd", !bad, n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
